fmap_stream_feeder: RTL and testbench

Source end of the convolution core's pixel and weight interface. It reads one kernel (NUM_WEIGHTS ternary-coded bytes) and one square feature map (input_depth × input_depth bytes) from synchronous-read memories. It drives w_req/w_in, start, d_in and the x1/y1 coordinate pair in the timing the core expects, then runs the coordinate counter on until the core reports done. It sits between the fmap/weight SRAMs and the convolution core, and one instance serves one core.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/raster_counter.sv | 53 +++++
 rtl/fmap_stream_feeder.sv | 167 ++++++++++++++++
 tb/tb_fmap_stream_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Constants and state encoding shared by the feeder and the conv core.
// Data width, max map side, kernel taps and the feeder FSM enum.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH  = 8;
  localparam int MAX_DEPTH       = 28;
  localparam int CNN_NUM_WEIGHTS = 9;
  localparam int COORD_W         = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WLAST,
    ST_LAUNCH,
    ST_STREAM,
    ST_DRAIN,
    ST_FINISH
  } feeder_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y wrap counter with a running linear address.
// Ports: clr > load > en; depth is the side; last flags (depth-1,depth-1).
module raster_counter #(
  parameter int AW = 10,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] depth,
  input  logic [AW-1:0] base,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic x_wrap;
  logic y_top;

  assign x_wrap = (x == depth - CW'(1));
  assign y_top  = (y == depth - CW'(1));
  assign last   = x_wrap && y_top;

  // y saturates on the bottom row so x can keep
  // wrapping there while the core drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clr) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (load) begin
      x    <= '0;
      y    <= '0;
      addr <= base;
    end else if (en) begin
      addr <= addr + AW'(1);
      if (x_wrap) begin
        x <= '0;
        if (!y_top) y <= y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_stream_feeder.sv
// Feeds one kernel and one square fmap from SRAMs into the conv core.
// Ports: go/clear ctrl, fmem/wmem read side, core w_req/w_in/start/x1/y1/d_in.
module fmap_stream_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH    = CNN_DATA_WIDTH,
  parameter int ADDR_WIDTH    = 10,
  parameter int WADDR_WIDTH   = 4,
  parameter int NUM_WEIGHTS   = CNN_NUM_WEIGHTS,
  parameter int DRAIN_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   go,
  input  logic                   clear,
  input  logic [COORD_W-1:0]     input_depth,
  input  logic [ADDR_WIDTH-1:0]  fmap_base,
  input  logic [WADDR_WIDTH-1:0] wgt_base,
  output logic                   fmem_rd_en,
  output logic [ADDR_WIDTH-1:0]  fmem_addr,
  input  logic [DATA_WIDTH-1:0]  fmem_rdata,
  output logic                   wmem_rd_en,
  output logic [WADDR_WIDTH-1:0] wmem_addr,
  input  logic [DATA_WIDTH-1:0]  wmem_rdata,
  output logic                   w_req,
  output logic [DATA_WIDTH-1:0]  w_in,
  output logic                   start,
  output logic [COORD_W-1:0]     x1,
  output logic [COORD_W-1:0]     y1,
  output logic [DATA_WIDTH-1:0]  d_in,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   err
);

  localparam int WKW = $clog2(NUM_WEIGHTS);
  localparam int TW  = $clog2(DRAIN_TIMEOUT + 1);

  feeder_state_e state;

  logic [COORD_W-1:0]    depth_q;
  logic [ADDR_WIDTH-1:0] fbase_q;
  logic [WKW-1:0]        wk;
  logic [TW-1:0]         dcnt;
  logic                  f_vld;

  logic cnt_clr;
  logic cnt_load;
  logic cnt_en;
  logic cnt_last;
  logic drain_to;
  logic drain_end;

  assign drain_to  = (dcnt == TW'(DRAIN_TIMEOUT - 1));
  assign drain_end = (state == ST_DRAIN) && (core_done || drain_to);

  assign cnt_clr  = clear || drain_end;
  assign cnt_load = (state == ST_LAUNCH);
  assign cnt_en   = (state == ST_STREAM) || (state == ST_DRAIN);

  raster_counter #(
    .AW (ADDR_WIDTH),
    .CW (COORD_W)
  ) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .load   (cnt_load),
    .en     (cnt_en),
    .depth  (depth_q),
    .base   (fbase_q),
    .x      (x1),
    .y      (y1),
    .addr   (fmem_addr),
    .last   (cnt_last)
  );

  // Memory data arrives the cycle after the strobe, so the
  // delayed strobes gate it straight through to the core.
  assign w_in = w_req ? wmem_rdata : '0;
  assign d_in = f_vld ? fmem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      depth_q    <= '0;
      fbase_q    <= '0;
      wk         <= '0;
      dcnt       <= '0;
      wmem_rd_en <= 1'b0;
      wmem_addr  <= '0;
      w_req      <= 1'b0;
      start      <= 1'b0;
      fmem_rd_en <= 1'b0;
      f_vld      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      wmem_rd_en <= 1'b0;
      w_req      <= 1'b0;
      start      <= 1'b0;
      fmem_rd_en <= 1'b0;
      f_vld      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      w_req <= wmem_rd_en;
      f_vld <= fmem_rd_en;
      start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            depth_q    <= input_depth;
            fbase_q    <= fmap_base;
            wmem_addr  <= wgt_base;
            wmem_rd_en <= 1'b1;
            wk         <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_WREQ;
          end
        end
        ST_WREQ: begin
          if (wk == WKW'(NUM_WEIGHTS - 1)) begin
            wmem_rd_en <= 1'b0;
            state      <= ST_WLAST;
          end else begin
            wk        <= wk + WKW'(1);
            wmem_addr <= wmem_addr + WADDR_WIDTH'(1);
          end
        end
        ST_WLAST: begin
          start <= 1'b1;
          state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          fmem_rd_en <= 1'b1;
          state      <= ST_STREAM;
        end
        ST_STREAM: begin
          if (cnt_last) begin
            fmem_rd_en <= 1'b0;
            dcnt       <= '0;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (core_done) begin
            state <= ST_FINISH;
          end else if (drain_to) begin
            err   <= 1'b1;
            state <= ST_FINISH;
          end else begin
            dcnt <= dcnt + TW'(1);
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_stream_feeder.sv
// Directed bench for fmap_stream_feeder with SRAM models.
// Instance a: default drain timeout; instance b: timeout 15, core_done low.
module tb_fmap_stream_feeder;

  localparam int AW  = 10;
  localparam int WAW = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic clear = 1'b0;
  logic core_done = 1'b0;
  logic [4:0] input_depth = '0;
  logic [AW-1:0] fmap_base = '0;
  logic [WAW-1:0] wgt_base = '0;

  logic a_frd, a_wrd, a_wreq, a_start, a_busy, a_err;
  logic [AW-1:0] a_faddr;
  logic [WAW-1:0] a_waddr;
  logic [DW-1:0] a_fdata = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_win, a_din;
  logic [4:0] a_x, a_y;

  logic b_frd, b_wrd, b_wreq, b_start, b_busy, b_err;
  logic [AW-1:0] b_faddr;
  logic [WAW-1:0] b_waddr;
  logic [DW-1:0] b_fdata = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [DW-1:0] b_win, b_din;
  logic [4:0] b_x, b_y;

  logic [DW-1:0] wmem [16];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // pixel value = low byte of its address
  always @(posedge clk) begin
    if (a_frd) a_fdata <= DW'(a_faddr);
    if (a_wrd) a_wdata <= wmem[a_waddr];
    if (b_frd) b_fdata <= DW'(b_faddr);
    if (b_wrd) b_wdata <= wmem[b_waddr];
  end

  fmap_stream_feeder dut_a (
    .clk (clk), .resetn (resetn), .go (go), .clear (clear),
    .input_depth (input_depth), .fmap_base (fmap_base),
    .wgt_base (wgt_base),
    .fmem_rd_en (a_frd), .fmem_addr (a_faddr),
    .fmem_rdata (a_fdata),
    .wmem_rd_en (a_wrd), .wmem_addr (a_waddr),
    .wmem_rdata (a_wdata),
    .w_req (a_wreq), .w_in (a_win), .start (a_start),
    .x1 (a_x), .y1 (a_y), .d_in (a_din),
    .core_done (core_done), .busy (a_busy), .err (a_err)
  );

  fmap_stream_feeder #(.DRAIN_TIMEOUT (15)) dut_b (
    .clk (clk), .resetn (resetn), .go (go), .clear (clear),
    .input_depth (input_depth), .fmap_base (fmap_base),
    .wgt_base (wgt_base),
    .fmem_rd_en (b_frd), .fmem_addr (b_faddr),
    .fmem_rdata (b_fdata),
    .wmem_rd_en (b_wrd), .wmem_addr (b_waddr),
    .wmem_rdata (b_wdata),
    .w_req (b_wreq), .w_in (b_win), .start (b_start),
    .x1 (b_x), .y1 (b_y), .d_in (b_din),
    .core_done (1'b0), .busy (b_busy), .err (b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 16; i++) wmem[i] = 8'hAA;
    wmem[2]  = 8'h01; wmem[3]  = 8'hFF; wmem[4]  = 8'h00;
    wmem[5]  = 8'h7F; wmem[6]  = 8'h80; wmem[7]  = 8'h02;
    wmem[8]  = 8'hFE; wmem[9]  = 8'h03; wmem[10] = 8'h55;

    // reset state
    #2;
    chk("rst_busy", a_busy, 0);
    chk("rst_err", a_err, 0);
    chk("rst_xy", {a_x, a_y}, 0);
    chk("rst_din_win", {a_din, a_win}, 0);
    chk("rst_strobes", {a_wreq, a_start, a_frd, a_wrd}, 0);
    #10 resetn = 1'b1;
    step();
    chk("idle_busy", a_busy, 0);

    // weight load + small map; core_done high early is ignored
    input_depth = 5'd4; fmap_base = 10'd100; wgt_base = 4'd2;
    go = 1'b1; core_done = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("wreq_rd_en", a_wrd, 1);
      chk("wreq_addr", a_waddr, 2 + k);
      chk("wreq_w_req", a_wreq, (k > 0));
      chk("wreq_w_in", a_win, (k > 0) ? wmem[1 + k] : 8'h00);
      chk("wreq_start", a_start, 0);
      step();
    end
    chk("wlast_rd_en", a_wrd, 0);
    chk("wlast_w_req", a_wreq, 1);
    chk("wlast_w_in", a_win, 8'h55);
    chk("wlast_start", a_start, 0);
    step();
    chk("launch_start", a_start, 1);
    chk("launch_w_req", a_wreq, 0);
    chk("launch_rd", a_frd, 0);
    chk("launch_xy", {a_x, a_y}, 0);
    step();
    for (int p = 0; p < 16; p++) begin
      chk("s4_rd_en", a_frd, 1);
      chk("s4_addr", a_faddr, 100 + p);
      chk("s4_x", a_x, p % 4);
      chk("s4_y", a_y, p / 4);
      chk("s4_din", a_din, (p == 0) ? 0 : 99 + p);
      chk("s4_start", a_start, 0);
      if (p == 5) begin go = 1'b1; fmap_base = 10'd500; end
      if (p == 6) begin go = 1'b0; fmap_base = 10'd100; end
      if (p == 15) core_done = 1'b0;
      step();
    end
    for (int j = 0; j < 3; j++) begin
      chk("d4_rd_en", a_frd, 0);
      chk("d4_y", a_y, 3);
      chk("d4_x", a_x, j);
      chk("d4_din", a_din, (j == 0) ? 115 : 0);
      if (j == 2) core_done = 1'b1;
      step();
    end
    core_done = 1'b0;
    chk("fin4_xy", {a_x, a_y}, 0);
    chk("fin4_busy", a_busy, 1);
    step();
    chk("idle4_busy", a_busy, 0);
    chk("idle4_err", a_err, 0);

    // instance b times out in this same run
    for (int i = 0; i < 40 && b_busy; i++) step();
    chk("b_to_idle", b_busy, 0);
    chk("b_to_err", b_err, 1);

    // full 28x28 map
    input_depth = 5'd28; fmap_base = 10'd0;
    go = 1'b1;
    step();
    go = 1'b0;
    chk("b_err_cleared_by_go", b_err, 0);
    chk("full_busy", a_busy, 1);
    step(11);
    bad = 0;
    for (int p = 0; p < 784; p++) begin
      if (a_frd !== 1'b1 || a_faddr !== AW'(p) ||
          a_x !== 5'(p % 28) || a_y !== 5'(p / 28) ||
          a_din !== ((p == 0) ? 8'h00 : DW'(p - 1)))
        bad++;
      step();
    end
    chk("full_stream_bad", bad, 0);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (a_frd !== 1'b0 || a_y !== 5'd27 || a_x !== 5'(j % 28))
        bad++;
      if (j == 14) chk("b_drain14_err", {b_busy, b_err}, 2'b10);
      if (j == 15) chk("b_fin_err", {b_busy, b_err}, 2'b11);
      if (j == 16) chk("b_idle_after_to", b_busy, 0);
      if (j == 39) begin
        chk("full_drain_busy", a_busy, 1);
        core_done = 1'b1;
      end
      step();
    end
    core_done = 1'b0;
    chk("full_drain_bad", bad, 0);
    chk("full_fin_xy", {a_x, a_y}, 0);
    chk("full_fin_busy", a_busy, 1);
    step();
    chk("full_idle_busy", a_busy, 0);
    chk("full_err", a_err, 0);

    // abort at pixel (5,3) of a 10x10 map
    input_depth = 5'd10; fmap_base = 10'd200;
    go = 1'b1;
    step();
    go = 1'b0;
    step(11 + 35);
    chk("ab_xy", {a_x, a_y}, {5'd5, 5'd3});
    chk("ab_addr", a_faddr, 235);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ab_busy", a_busy, 0);
    chk("ab_rd_en", a_frd, 0);
    chk("ab_xy0", {a_x, a_y}, 0);
    chk("ab_din", a_din, 0);
    chk("ab_err", {a_err, b_err}, 0);

    // go and clear together: clear wins
    input_depth = 5'd4; fmap_base = 10'd100;
    go = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("goclr_busy", a_busy, 0);
    chk("goclr_wrd", a_wrd, 0);
    step();
    go = 1'b0;
    chk("restart_busy", a_busy, 1);
    chk("restart_wrd", a_wrd, 1);
    chk("restart_waddr", a_waddr, 2);

    // async reset mid-DRAIN
    step(11 + 16 + 2);
    chk("pre_rst_xy", {a_x, a_y}, {5'd2, 5'd3});
    #1;
    resetn = 1'b0; go = 1'b1;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_xy", {a_x, a_y}, 0);
    chk("arst_rd", {a_frd, a_wrd, a_wreq, a_start}, 0);
    chk("arst_addr", a_faddr, 0);
    chk("arst_din", a_din, 0);
    #2;
    resetn = 1'b1; go = 1'b0;
    step();
    chk("post_rst_busy", a_busy, 0);
    chk("post_rst_wrd", a_wrd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
